// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared counter encodings, BTB entry type and NOP constant for the fetch stage
package fetch_pkg;

  // 2-bit saturating branch-history counter states
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  // Tag and target fields are sized for the widest supported PC; narrower PCs are zero-extended
  localparam int BTB_FIELD_W = 16;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT + BTB direction/target predictor, built only under FETCH_BP_EN
`ifdef FETCH_BP_EN
module branch_predictor
  import fetch_pkg::*;
#(
  parameter int PC_BITS      = 5,
  parameter int BHT_IDX_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] i_lookup_pc,
  output logic               o_pred_taken,
  output logic [PC_BITS-1:0] o_pred_target,
  input  logic               i_upd_valid,
  input  logic [PC_BITS-1:0] i_upd_pc,
  input  logic               i_upd_taken,
  input  logic [PC_BITS-1:0] i_upd_target
);

  localparam int ENTRIES  = 1 << BHT_IDX_BITS;
  localparam int TAG_BITS = PC_BITS - BHT_IDX_BITS;

  bht_ctr_t   r_bht [ENTRIES];
  btb_entry_t r_btb [ENTRIES];

  logic [BHT_IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]     w_lk_tag;
  logic [BHT_IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]     w_up_tag;
  bht_ctr_t                w_lk_ctr;
  btb_entry_t              w_lk_entry;
  bht_ctr_t                w_up_cur;
  bht_ctr_t                w_up_ctr;

  assign w_lk_idx   = i_lookup_pc[BHT_IDX_BITS-1:0];
  assign w_lk_tag   = i_lookup_pc[PC_BITS-1:BHT_IDX_BITS];
  assign w_up_idx   = i_upd_pc[BHT_IDX_BITS-1:0];
  assign w_up_tag   = i_upd_pc[PC_BITS-1:BHT_IDX_BITS];
  assign w_lk_ctr   = r_bht[w_lk_idx];
  assign w_lk_entry = r_btb[w_lk_idx];
  assign w_up_cur   = r_bht[w_up_idx];

  // Lookup reads registered state only, so a same-cycle update is seen one cycle later
  assign o_pred_taken  = ((w_lk_ctr == WT) || (w_lk_ctr == ST)) && w_lk_entry.valid &&
                         (w_lk_entry.tag == BTB_FIELD_W'(w_lk_tag));
  assign o_pred_target = PC_BITS'(w_lk_entry.target);

  // Saturating increment on taken, saturating decrement on not-taken
  always_comb begin
    w_up_ctr = w_up_cur;
    if (i_upd_taken) begin
      if (w_up_cur != ST) w_up_ctr = w_up_cur + 2'd1;
    end else begin
      if (w_up_cur != SNT) w_up_ctr = w_up_cur - 2'd1;
    end
  end

  // Counter table: reset to weakly not-taken, train on every resolved branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bht <= '{default: WNT};
    end else if (i_upd_valid) begin
      r_bht[w_up_idx] <= w_up_ctr;
    end
  end

  // Target buffer: only taken branches allocate; not-taken leaves the entry alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btb <= '{default: btb_entry_t'('0)};
    end else if (i_upd_valid && i_upd_taken) begin
      r_btb[w_up_idx] <= '{valid: 1'b1,
                           tag: BTB_FIELD_W'(w_up_tag),
                           target: BTB_FIELD_W'(i_upd_target)};
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and next-PC select; predictor included when FETCH_BP_EN is defined
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PC_BITS      = 5,
  parameter int BHT_IDX_BITS = 3,
  parameter int RESET_PC     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_F,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_target,
  input  logic               EX_br_valid,
  input  logic [PC_BITS-1:0] EX_br_pc,
  input  logic               EX_br_outcome,
  input  logic [PC_BITS-1:0] EX_br_target,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken
);

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] w_pc_plus1;
  logic [PC_BITS-1:0] w_next_pc;
  logic               w_bp_taken;
  logic [PC_BITS-1:0] w_bp_target;

  assign w_pc_plus1 = r_pc + PC_BITS'(1);

`ifdef FETCH_BP_EN
  branch_predictor #(
    .PC_BITS      (PC_BITS),
    .BHT_IDX_BITS (BHT_IDX_BITS)
  ) u_bp (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_pc   (r_pc),
    .o_pred_taken  (w_bp_taken),
    .o_pred_target (w_bp_target),
    .i_upd_valid   (EX_br_valid),
    .i_upd_pc      (EX_br_pc),
    .i_upd_taken   (EX_br_outcome),
    .i_upd_target  (EX_br_target)
  );
`else
  logic w_unused_br;
  assign w_bp_taken  = 1'b0;
  assign w_bp_target = w_pc_plus1;
  assign w_unused_br = ^{EX_br_valid, EX_br_pc, EX_br_outcome, EX_br_target, BHT_IDX_BITS};
`endif

  // Next PC: redirect beats stall, stall beats prediction, otherwise sequential with wrap
  always_comb begin
    w_next_pc = w_pc_plus1;
    if (EX_taken)        w_next_pc = EX_target;
    else if (stall_F)    w_next_pc = r_pc;
    else if (w_bp_taken) w_next_pc = w_bp_target;
  end

  // PC register, forced to the reset vector asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= PC_BITS'(RESET_PC);
    else     r_pc <= w_next_pc;
  end

  assign F_pc       = r_pc;
  assign imem_addr  = r_pc;
  assign F_inst     = imem_rdata;
  assign F_BP_taken = w_bp_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table, async reset sequence and randomized model check of fetch_unit
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_BP_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_F = 1'b0;
  logic        EX_taken = 1'b0;
  logic [4:0]  EX_target = '0;
  logic        EX_br_valid = 1'b0;
  logic [4:0]  EX_br_pc = '0;
  logic        EX_br_outcome = 1'b0;
  logic [4:0]  EX_br_target = '0;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  F_pc;
  logic [31:0] F_inst;
  logic        F_BP_taken;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int a);
    if (a == 31) return NOP_INST;
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_0111;
  endfunction

  assign imem_rdata = mem_word(int'(imem_addr));

  fetch_unit #(.XLEN(32), .PC_BITS(5), .BHT_IDX_BITS(3), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .EX_taken(EX_taken), .EX_target(EX_target),
    .EX_br_valid(EX_br_valid), .EX_br_pc(EX_br_pc), .EX_br_outcome(EX_br_outcome),
    .EX_br_target(EX_br_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .F_pc(F_pc), .F_inst(F_inst), .F_BP_taken(F_BP_taken)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer counters and per-index BTB fields
  int m_pc;
  int m_cnt [8];
  bit m_vld [8];
  int m_tag [8];
  int m_tgt [8];

  function automatic bit m_pred(input int pc);
    int i;
    i = pc % 8;
    return BP_ON && (m_cnt[i] >= 2) && m_vld[i] && (m_tag[i] == pc / 8);
  endfunction

  task automatic m_reset();
    m_pc = 0;
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 1;
      m_vld[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
  endtask

  task automatic step();
    int nxt;
    int i;
    if (EX_taken)          nxt = int'(EX_target);
    else if (stall_F)      nxt = m_pc;
    else if (m_pred(m_pc)) nxt = m_tgt[m_pc % 8];
    else                   nxt = (m_pc + 1) % 32;
    if (BP_ON && EX_br_valid) begin
      i = int'(EX_br_pc) % 8;
      if (EX_br_outcome) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_vld[i] = 1'b1;
        m_tag[i] = int'(EX_br_pc) / 8;
        m_tgt[i] = int'(EX_br_target);
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit e, input int et, input bit bv,
                       input int bpc, input bit bo, input int bt);
    stall_F       = s;
    EX_taken      = e;
    EX_target     = 5'(et);
    EX_br_valid   = bv;
    EX_br_pc      = 5'(bpc);
    EX_br_outcome = bo;
    EX_br_target  = 5'(bt);
  endtask

  typedef struct {
    bit stall; bit ext; int et; bit bv; int bpc; bit bo; int bt;
    int exp_pc; bit exp_bp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit s, input bit e, input int et, input bit bv, input int bpc,
                     input bit bo, input int bt, input int pc_on, input bit bp_on, input int pc_off);
    vec_t v;
    v.stall = s; v.ext = e; v.et = et; v.bv = bv; v.bpc = bpc; v.bo = bo; v.bt = bt;
    v.exp_pc = BP_ON ? pc_on : pc_off;
    v.exp_bp = BP_ON ? bp_on : 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, e, bv, bo;
    int et, bpc, bt, sel;

    // stall, ext, et, bv, bpc, bo, bt, pc_on, bp_on, pc_off
    add(0,0,0, 0,0,0,0,  0,0, 0);
    add(0,0,0, 0,0,0,0,  1,0, 1);
    add(0,0,0, 0,0,0,0,  2,0, 2);
    add(0,0,0, 0,0,0,0,  3,0, 3);
    add(0,0,0, 0,0,0,0,  4,0, 4);
    add(0,0,0, 0,0,0,0,  5,0, 5);
    add(1,0,0, 0,0,0,0,  6,0, 6);
    add(1,0,0, 0,0,0,0,  6,0, 6);
    add(1,0,0, 0,0,0,0,  6,0, 6);
    add(0,0,0, 0,0,0,0,  6,0, 6);
    add(1,1,17,0,0,0,0,  7,0, 7);
    add(0,0,0, 0,0,0,0, 17,0,17);
    add(0,1,31,0,0,0,0, 18,0,18);
    add(0,0,0, 0,0,0,0, 31,0,31);
    add(0,0,0, 0,0,0,0,  0,0, 0);
    add(0,0,0, 1,4,1,9,  1,0, 1);
    add(0,0,0, 1,4,1,9,  2,0, 2);
    add(0,0,0, 0,0,0,0,  3,0, 3);
    add(0,0,0, 0,0,0,0,  4,1, 4);
    add(0,0,0, 0,0,0,0,  9,0, 5);
    add(0,1,4, 1,4,0,0, 10,0, 6);
    add(0,0,0, 0,0,0,0,  4,1, 4);
    add(0,0,0, 1,4,0,0,  9,0, 5);
    add(0,1,4, 0,0,0,0, 10,0, 6);
    add(0,0,0, 0,0,0,0,  4,0, 4);
    add(0,0,0, 0,0,0,0,  5,0, 5);
    add(0,0,0, 1,4,1,9,  6,0, 6);
    add(0,0,0, 1,4,1,9,  7,0, 7);
    add(0,1,12,0,0,0,0,  8,0, 8);
    add(0,0,0, 0,0,0,0, 12,0,12);
    add(0,0,0, 0,0,0,0, 13,0,13);
    add(0,1,4, 0,0,0,0, 14,0,14);
    add(0,0,0, 1,4,0,0,  4,1, 4);
    add(0,0,0, 0,0,0,0,  9,0, 5);

    m_reset();
    #2;
    check("reset_pc", 32'(F_pc), 0);
    check("reset_bp", 32'(F_BP_taken), 0);
    @(posedge clk);
    #1;
    check("reset_hold_pc", 32'(F_pc), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].ext, vecs[i].et, vecs[i].bv, vecs[i].bpc, vecs[i].bo, vecs[i].bt);
      #1;
      check($sformatf("vec%0d_pc", i), 32'(F_pc), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_bp", i), 32'(F_BP_taken), 32'(vecs[i].exp_bp));
      check($sformatf("vec%0d_inst", i), F_inst, mem_word(vecs[i].exp_pc));
      check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_pc));
      step();
    end

    // Mid-operation reset with a redirect and an update pending
    drive(0, 1, 20, 1, 4, 1, 9);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", 32'(F_pc), 0);
    check("async_rst_bp", 32'(F_BP_taken), 0);
    @(posedge clk);
    #1;
    check("rst_discard_redirect", 32'(F_pc), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("post_rst%0d_pc", i), 32'(F_pc), 32'(i));
      check($sformatf("post_rst%0d_bp", i), 32'(F_BP_taken), 0);
      step();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      s   = ($urandom_range(0, 4) == 0);
      e   = ($urandom_range(0, 9) == 0);
      et  = $urandom_range(0, 31);
      bv  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 3);
      bpc = (sel == 0) ? 4 : (sel == 1) ? 12 : (sel == 2) ? m_pc : $urandom_range(0, 31);
      bo  = ($urandom_range(0, 9) < 7);
      bt  = $urandom_range(0, 31);
      drive(s, e, et, bv, bpc, bo, bt);
      #1;
      check($sformatf("rnd%0d_pc", n), 32'(F_pc), 32'(m_pc));
      check($sformatf("rnd%0d_bp", n), 32'(F_BP_taken), 32'(m_pred(m_pc)));
      check($sformatf("rnd%0d_inst", n), F_inst, mem_word(m_pc));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: instruction width.
REQ-002 Parameter PC_BITS, default 5: word-address PC width.
REQ-003 Parameter BHT_IDX_BITS, default 3: predictor index width, 2^BHT_IDX_BITS entries, less than PC_BITS.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Port clk, in, 1: sole clock, rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous, active-high.
REQ-007 Port stall_F, in, 1: hold the current PC.
REQ-008 Port EX_taken, in, 1: redirect/flush request from EX.
REQ-009 Port EX_target, in, PC_BITS: redirect PC.
REQ-010 Port EX_br_valid, in, 1: a branch resolved in EX this cycle.
REQ-011 Port EX_br_pc, in, PC_BITS: PC of the resolved branch.
REQ-012 Port EX_br_outcome, in, 1: resolved direction, 1 = taken.
REQ-013 Port EX_br_target, in, PC_BITS: resolved branch target.
REQ-014 Port imem_addr, out, PC_BITS: instruction memory address, equal to F_pc.
REQ-015 Port imem_rdata, in, XLEN: combinational instruction memory read data.
REQ-016 Port F_pc, out, PC_BITS: PC of the fetched instruction.
REQ-017 Port F_inst, out, XLEN: fetched instruction, equal to imem_rdata.
REQ-018 Port F_BP_taken, out, 1: prediction made for F_pc.

Function
REQ-019 The block SHALL hold the PC register; F_pc SHALL be the PC register output.
- Zero-latency fetch: F_inst and F_BP_taken are combinational from F_pc in the same cycle.
REQ-020 The next PC SHALL use this priority:
- EX_taken: EX_target.
- Else stall_F: hold the PC.
- Else F_BP_taken: predicted target.
- Else PC+1, modulo 2^PC_BITS, so PC 2^PC_BITS-1 wraps to 0.
REQ-021 EX_taken SHALL override stall_F when both are asserted in the same cycle.
REQ-022 The predictor SHALL use a BHT of 2-bit saturating counters and a BTB holding a valid bit, a tag and a target per entry.
- Index: PC[BHT_IDX_BITS-1:0].
- Tag: the upper PC_BITS-BHT_IDX_BITS PC bits.
REQ-023 F_BP_taken SHALL be 1 only when all three hold: the counter is 2 or 3, the BTB entry is valid, and the BTB tag matches.
REQ-024 On EX_br_valid the counter at the index of EX_br_pc SHALL update at the clock edge.
- Outcome 1: increment, saturating at 3.
- Outcome 0: decrement, saturating at 0.
REQ-025 On EX_br_valid with EX_br_outcome=1 the BTB entry at the index of EX_br_pc SHALL be written with valid=1, the tag of EX_br_pc and EX_br_target.
- On outcome 0 the BTB entry SHALL be left unchanged.
REQ-026 When an update and a lookup hit the same index in one cycle, the lookup SHALL see the pre-update state; the update becomes visible the next cycle.
REQ-027 Predictor updates SHALL proceed regardless of stall_F and EX_taken.

Reset
REQ-028 While rst=1 the block SHALL force all of the following:
- PC = RESET_PC.
- All counters = 01 (weakly not-taken).
- All BTB valid bits = 0.
REQ-029 Asserting rst mid-operation SHALL take effect without waiting for a clock edge and SHALL discard any pending redirect or update.
- After release, F_BP_taken=0 until a taken branch has been trained.

Configuration
REQ-030 The macro FETCH_BP_EN SHALL select predictor support.
- Defined: the predictor exists as specified in REQ-022..REQ-027.
- Undefined: no BHT/BTB storage is built, F_BP_taken is tied to 0, next PC = PC+1, and the EX_br_* inputs are ignored.

Structure
REQ-031 The shared package fetch_pkg SHALL hold:
- Counter encoding constants SNT=00, WNT=01, WT=10, ST=11.
- The BTB entry typedef (valid, tag, target).
- The NOP instruction constant.
REQ-032 The predictor SHALL live in a sub-module branch_predictor containing the BHT, the BTB, the lookup and the update.
- fetch_unit holds the PC register and the next-PC mux.

Verification
REQ-033 Reset: rst=1 with RESET_PC=0 -> F_pc=0, F_BP_taken=0; after release with no stall -> F_pc 0,1,2 on successive cycles.
REQ-034 Wrap and stall: PC=31 with stall_F=0 -> next F_pc=0; stall_F=1 for 3 cycles at PC=6 -> F_pc stays 6 and F_inst stays stable.
REQ-035 Redirect priority: stall_F=1 and EX_taken=1 with EX_target=17 in the same cycle -> next F_pc=17.
REQ-036 Training: two EX_br_valid updates with EX_br_pc=4, outcome=1, target=9; then fetch PC 4 -> F_BP_taken=1 and next F_pc=9.
- Then one outcome=0 update -> counter back to 10, still predicts taken.
- A second outcome=0 update -> counter 01, PC 4 then yields F_BP_taken=0 and next F_pc=5.
REQ-037 Alias: with PC 4 trained, fetch PC 12 (same index, different tag) -> F_BP_taken=0 and next F_pc=13.
REQ-038 Macro off: build without FETCH_BP_EN and repeat REQ-036 -> F_BP_taken always 0 and PC 4 is followed by 5.
